// File: rtl/serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_compare_ctrl
// Description : Bit-serial, MSB-first magnitude compare of two unsigned
//               operands through a 1-bit l/e/g slice, with start/busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a_in,
    input  logic [WIDTH-1:0]         b_in,
    output logic                     busy,
    output logic                     done,
    output logic                     lt,
    output logic                     eq,
    output logic                     gt,
    output logic [$clog2(WIDTH)-1:0] diff_idx
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] c_idx_msb = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_found;
    logic               r_busy;
    logic               r_done;
    logic               r_lt;
    logic               r_eq;
    logic               r_gt;
    logic [IDX_W-1:0]   r_diff_idx;

    // Shared 1-bit comparator slice on the currently selected bit
    logic w_bit_a;
    logic w_bit_b;
    logic w_l;
    logic w_e;
    logic w_g;
    logic w_last;

    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];
    assign w_l     = ~w_bit_a & w_bit_b;
    assign w_e     = ~(w_bit_a ^ w_bit_b);
    assign w_g     = w_bit_a & ~w_bit_b;
    assign w_last  = (r_idx == '0) || (EARLY_EXIT && !w_e);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lt       <= 1'b0;
            r_eq       <= 1'b0;
            r_gt       <= 1'b0;
            r_diff_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a        <= a_in;
                        r_b        <= b_in;
                        r_idx      <= c_idx_msb;
                        r_found    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_lt       <= 1'b0;
                        r_eq       <= 1'b0;
                        r_gt       <= 1'b0;
                        r_diff_idx <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Only the highest differing bit decides; later ones are ignored
                    if (!w_e && !r_found) begin
                        r_found    <= 1'b1;
                        r_lt       <= w_l;
                        r_gt       <= w_g;
                        r_diff_idx <= r_idx;
                    end
                    if (w_last) begin
                        if (!r_found && w_e) begin
                            r_eq       <= 1'b1;
                            r_diff_idx <= '0;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign lt       = r_lt;
    assign eq       = r_eq;
    assign gt       = r_gt;
    assign diff_idx = r_diff_idx;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mag_compare_ctrl
// Description : Scoreboard bench for serial_mag_compare_ctrl, one instance
//               with early exit and one with fixed latency (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start0;
    logic [7:0] a1, b1, a0, b0;
    logic       busy1, done1, lt1, eq1, gt1;
    logic       busy0, done0, lt0, eq0, gt0;
    logic [2:0] idx1, idx0;

    always #5 clk = ~clk;

    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .diff_idx(idx1)
    );

    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst(rst), .start(start0), .a_in(a0), .b_in(b0),
        .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0), .diff_idx(idx0)
    );

    typedef struct packed {
        logic       lt;
        logic       eq;
        logic       gt;
        logic [2:0] idx;
        int         n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input bit ee, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e    = '0;
        e.eq = 1'b1;
        e.n  = 8;
        for (int i = 7; i >= 0; i--) begin
            if (e.eq && (a[i] != b[i])) begin
                e.eq  = 1'b0;
                e.lt  = b[i];
                e.gt  = a[i];
                e.idx = 3'(i);
                if (ee) e.n = 8 - i;
            end
        end
        return e;
    endfunction

    // Drives one start pulse, scrambles operands during RUN, waits for done.
    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          output int bc, output int dc, output logic [5:0] res);
        logic       ob, od;
        logic [5:0] r;
        bc  = 0;
        dc  = -1;
        res = '0;
        @(negedge clk);
        if (sel) begin a1 = a; b1 = b; start1 = 1'b1; end
        else     begin a0 = a; b0 = b; start0 = 1'b1; end
        @(posedge clk);
        #1;
        start1 = 1'b0; start0 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom);
        a0 = 8'($urandom); b0 = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (sel) begin ob = busy1; od = done1; r = {lt1, eq1, gt1, idx1}; end
            else     begin ob = busy0; od = done0; r = {lt0, eq0, gt0, idx0}; end
            if (ob) bc++;
            if (od) begin
                dc  = c;
                res = r;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start1 = 1'b0; start0 = 1'b0;
        a1 = '0; b1 = '0; a0 = '0; b0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy1, done1, lt1, eq1, gt1, idx1} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ee1: got %b expected 00000000", {busy1, done1, lt1, eq1, gt1, idx1});
        end
        checks++;
        if ({busy0, done0, lt0, eq0, gt0, idx0} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ee0: got %b expected 00000000", {busy0, done0, lt0, eq0, gt0, idx0});
        end
        rst = 1'b0;
    endtask

    task automatic check_ops(input string name, input bit sel,
                             input logic [7:0] av[], input logic [7:0] bv[]);
        int         bc, dc;
        logic [5:0] res;
        exp_t       e;
        for (int k = 0; k < av.size(); k++) begin
            sb.push_back(model(sel, av[k], bv[k]));
            run_op(sel, av[k], bv[k], bc, dc, res);
            e = sb.pop_front();
            checks++;
            if (bc !== e.n || dc !== e.n + 1) begin
                failures++;
                $display("FAIL %s_timing a=%h b=%h: busy=%0d done_cycle=%0d expected busy=%0d done_cycle=%0d",
                         name, av[k], bv[k], bc, dc, e.n, e.n + 1);
            end
            checks++;
            if (res !== {e.lt, e.eq, e.gt, e.idx}) begin
                failures++;
                $display("FAIL %s_result a=%h b=%h: lt/eq/gt/idx=%b expected %b",
                         name, av[k], bv[k], res, {e.lt, e.eq, e.gt, e.idx});
            end
        end
    endtask

    task automatic test_early_exit;
        logic [7:0] av[] = '{8'hA5, 8'h80, 8'h12, 8'h00, 8'hFF};
        logic [7:0] bv[] = '{8'hA5, 8'h7F, 8'h13, 8'hFF, 8'h00};
        check_ops("early_exit", 1'b1, av, bv);
    endtask

    task automatic test_fixed_latency;
        logic [7:0] av[] = '{8'h80, 8'h12, 8'h3C, 8'h40};
        logic [7:0] bv[] = '{8'h7F, 8'h13, 8'h3C, 8'h5F};
        check_ops("fixed_latency", 1'b0, av, bv);
    endtask

    task automatic test_random;
        logic [7:0] av[] = new[12];
        logic [7:0] bv[] = new[12];
        for (int k = 0; k < 12; k++) begin
            av[k] = 8'($urandom);
            bv[k] = (k % 4 == 0) ? av[k] : 8'($urandom);
        end
        check_ops("random_ee1", 1'b1, av, bv);
        check_ops("random_ee0", 1'b0, av, bv);
    endtask

    task automatic test_hold;
        int         bc, dc;
        logic [5:0] res;
        run_op(1'b0, 8'h05, 8'h09, bc, dc, res);
        repeat (4) @(negedge clk);
        checks++;
        if ({done0, lt0, eq0, gt0, idx0} !== {1'b0, 6'b100_011}) begin
            failures++;
            $display("FAIL hold: done/lt/eq/gt/idx=%b expected 0100011", {done0, lt0, eq0, gt0, idx0});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] av[3] = '{8'h80, 8'h01, 8'hC3};
        logic [7:0] bv[3] = '{8'h7F, 8'h01, 8'hC7};
        exp_t e;
        int   k  = 0;
        int   c  = 0;
        int   bc = 0;
        @(negedge clk);
        a1 = av[0]; b1 = bv[0]; start1 = 1'b1;
        sb.push_back(model(1'b1, av[0], bv[0]));
        for (int t = 0; t < 100 && k < 3; t++) begin
            @(negedge clk);
            c++;
            if (busy1) begin
                bc++;
                a1 = 8'($urandom); b1 = 8'($urandom);
            end
            if (done1) begin
                e = sb.pop_front();
                checks++;
                if (bc !== e.n || c !== e.n + 1) begin
                    failures++;
                    $display("FAIL b2b_timing op%0d: busy=%0d done_cycle=%0d expected busy=%0d done_cycle=%0d",
                             k, bc, c, e.n, e.n + 1);
                end
                checks++;
                if ({lt1, eq1, gt1, idx1} !== {e.lt, e.eq, e.gt, e.idx}) begin
                    failures++;
                    $display("FAIL b2b_result op%0d: lt/eq/gt/idx=%b expected %b",
                             k, {lt1, eq1, gt1, idx1}, {e.lt, e.eq, e.gt, e.idx});
                end
                k++;
                bc = 0;
                c  = -1;
                if (k < 3) begin
                    a1 = av[k]; b1 = bv[k];
                    sb.push_back(model(1'b1, av[k], bv[k]));
                end
            end
        end
        start1 = 1'b0;
        checks++;
        if (k !== 3) begin
            failures++;
            $display("FAIL b2b_timeout: completed=%0d expected 3", k);
        end
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        @(negedge clk);
        a1 = 8'hA5; b1 = 8'hA5; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: busy=%b expected 1", busy1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy1, done1, lt1, eq1, gt1, idx1} !== 8'h00) begin
            failures++;
            $display("FAIL abort_cleared: got %b expected 00000000", {busy1, done1, lt1, eq1, gt1, idx1});
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d expected 0", dones);
        end
        begin
            logic [7:0] av[] = '{8'h3C};
            logic [7:0] bv[] = '{8'h3D};
            check_ops("after_abort", 1'b1, av, bv);
        end
    endtask

    initial begin
        test_reset;
        test_early_exit;
        test_fixed_latency;
        test_random;
        test_hold;
        test_back_to_back;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
